// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control unit.
// Moore FSM that sequences fetch/decode/execute/memory/writeback and drives
// every datapath enable, select and the ALU operation code. The only Mealy
// term is pc_en, which folds in the ALU zero flag during BRANCH.
module mc_control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_cnt,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       pc_en,
  output logic       retire,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     r_state;
  state_t     w_next_state;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_retire;
  logic [2:0] w_funct_op;

  // R-type funct to ALU operation; unrecognised functs fall back to add.
  always_comb begin
    unique case (funct)
      6'b100000: w_funct_op = ALU_ADD;
      6'b100010: w_funct_op = ALU_SUB;
      6'b100100: w_funct_op = ALU_AND;
      6'b100101: w_funct_op = ALU_OR;
      6'b101010: w_funct_op = ALU_SLT;
      default:   w_funct_op = ALU_ADD;
    endcase
  end

  // State register; reset lands in FETCH without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // Next-state selection; illegal encodings fall through to FETCH.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: w_next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next_state = S_MEMWB;
      S_EXEC:   w_next_state = S_ALUWB;
      S_ADDIEX: w_next_state = S_ADDIWB;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Moore output decode; anything not named for a state stays at default.
  always_comb begin
    alu_cnt     = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        alu_src_b  = 2'b01;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_cnt   = w_funct_op;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_cnt   = ALU_SUB;
        pc_src    = 2'b01;
        w_branch  = 1'b1;
        w_retire  = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        w_pc_write = 1'b1;
        w_retire   = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: strobes are gated by rst_n combinationally so reset suppresses them
  // in the same instant, not one clock later.
  assign mem_write = w_mem_write & rst_n;
  assign ir_write  = w_ir_write & rst_n;
  assign reg_write = w_reg_write & rst_n;
  assign retire    = w_retire & rst_n;
  assign pc_en     = (w_pc_write | (w_branch & zero)) & rst_n;
  assign state     = r_state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: a driver applies directed instruction sequences
// one cycle at a time and queues the hand-derived output vector for that
// cycle; a monitor pops and compares at the falling edge.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero;
  logic [2:0] alu_cnt;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       pc_en, retire;
  logic [3:0] state;

  mc_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_cnt(alu_cnt), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .pc_en(pc_en), .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  // Vector layout: state[19:16] alu_cnt[15:13] src_a[12] src_b[11:10]
  // pc_src[9:8] then iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,pc_en,retire
  localparam logic [19:0] E_RST    = {4'd0,  3'b010, 1'b0, 2'b01, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_FETCH  = {4'd0,  3'b010, 1'b0, 2'b01, 2'b00, 8'b0010_0010};
  localparam logic [19:0] E_DECODE = {4'd1,  3'b010, 1'b0, 2'b11, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_MEMADR = {4'd2,  3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_MEMRD  = {4'd3,  3'b010, 1'b0, 2'b00, 2'b00, 8'b1000_0000};
  localparam logic [19:0] E_MEMWB  = {4'd4,  3'b010, 1'b0, 2'b00, 2'b00, 8'b0000_1101};
  localparam logic [19:0] E_MEMWR  = {4'd5,  3'b010, 1'b0, 2'b00, 2'b00, 8'b1100_0001};
  localparam logic [19:0] E_EX_SUB = {4'd6,  3'b110, 1'b1, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_EX_ADD = {4'd6,  3'b010, 1'b1, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_EX_SLT = {4'd6,  3'b111, 1'b1, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_ALUWB  = {4'd7,  3'b010, 1'b0, 2'b00, 2'b00, 8'b0001_0101};
  localparam logic [19:0] E_BR_T   = {4'd8,  3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0011};
  localparam logic [19:0] E_BR_N   = {4'd8,  3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0001};
  localparam logic [19:0] E_ADDIEX = {4'd9,  3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_ADDIWB = {4'd10, 3'b010, 1'b0, 2'b00, 2'b00, 8'b0000_0101};
  localparam logic [19:0] E_JUMP   = {4'd11, 3'b010, 1'b0, 2'b00, 2'b10, 8'b0000_0011};

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] FN_SUB = 6'b100010, FN_SLT = 6'b101010, FN_BAD = 6'b000000;

  logic [19:0] exp_q[$];
  int          tag_q[$];
  int          tag = 0;
  int          total = 0;
  int          bad = 0;
  event        mon_ev;

  wire [19:0] act = {state, alu_cnt, alu_src_a, alu_src_b, pc_src, iord, mem_write,
                     ir_write, reg_dst, mem_to_reg, reg_write, pc_en, retire};

  task automatic check(input int id, input logic [19:0] a, input logic [19:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL step%0d: got state=%0d alu=%b a=%b b=%b pcs=%b en=%b need state=%0d alu=%b a=%b b=%b pcs=%b en=%b",
               id, a[19:16], a[15:13], a[12], a[11:10], a[9:8], a[7:0],
               e[19:16], e[15:13], e[12], e[11:10], e[9:8], e[7:0]);
    end
  endtask

  task automatic push(input logic [19:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    tag++;
  endtask

  // One cycle: drive inputs just after the rising edge, queue expected outputs.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic [19:0] e);
    @(posedge clk);
    #1;
    opcode = op;
    funct  = fn;
    zero   = z;
    push(e);
  endtask

  // Monitor: compare everything queued at each falling edge or on request.
  initial begin
    forever begin
      @(negedge clk or mon_ev);
      while (exp_q.size() > 0) check(tag_q.pop_front(), act, exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; opcode = OP_R; funct = FN_SUB; zero = 1'b0;
    // Held in reset: FETCH look, all strobes low.
    step(OP_R, FN_SUB, 1'b0, E_RST);
    step(OP_R, FN_SUB, 1'b0, E_RST);
    @(posedge clk); #1; rst_n = 1'b1; push(E_FETCH);
    // R-type sub
    step(OP_R, FN_SUB, 1'b0, E_DECODE);
    step(OP_R, FN_SUB, 1'b0, E_EX_SUB);
    step(OP_R, FN_SUB, 1'b0, E_ALUWB);
    // lw
    step(OP_LW, FN_SUB, 1'b0, E_FETCH);
    step(OP_LW, FN_SUB, 1'b0, E_DECODE);
    step(OP_LW, FN_SUB, 1'b0, E_MEMADR);
    step(OP_LW, FN_SUB, 1'b0, E_MEMRD);
    step(OP_LW, FN_SUB, 1'b0, E_MEMWB);
    // beq taken, then not taken
    step(OP_BEQ, FN_SUB, 1'b0, E_FETCH);
    step(OP_BEQ, FN_SUB, 1'b0, E_DECODE);
    step(OP_BEQ, FN_SUB, 1'b1, E_BR_T);
    step(OP_BEQ, FN_SUB, 1'b0, E_FETCH);
    step(OP_BEQ, FN_SUB, 1'b0, E_DECODE);
    step(OP_BEQ, FN_SUB, 1'b0, E_BR_N);
    // sw with zero high outside BRANCH (must be ignored), then j
    step(OP_SW, FN_SUB, 1'b1, E_FETCH);
    step(OP_SW, FN_SUB, 1'b1, E_DECODE);
    step(OP_SW, FN_SUB, 1'b1, E_MEMADR);
    step(OP_SW, FN_SUB, 1'b1, E_MEMWR);
    step(OP_J,  FN_SUB, 1'b0, E_FETCH);
    step(OP_J,  FN_SUB, 1'b0, E_DECODE);
    step(OP_J,  FN_SUB, 1'b0, E_JUMP);
    // unknown opcode: two-cycle NOP
    step(OP_BAD, FN_SUB, 1'b0, E_FETCH);
    step(OP_BAD, FN_SUB, 1'b0, E_DECODE);
    // addi
    step(OP_ADDI, FN_SUB, 1'b0, E_FETCH);
    step(OP_ADDI, FN_SUB, 1'b0, E_DECODE);
    step(OP_ADDI, FN_SUB, 1'b0, E_ADDIEX);
    step(OP_ADDI, FN_SUB, 1'b0, E_ADDIWB);
    // R-type with unknown funct, then slt
    step(OP_R, FN_BAD, 1'b0, E_FETCH);
    step(OP_R, FN_BAD, 1'b0, E_DECODE);
    step(OP_R, FN_BAD, 1'b0, E_EX_ADD);
    step(OP_R, FN_BAD, 1'b0, E_ALUWB);
    step(OP_R, FN_SLT, 1'b0, E_FETCH);
    step(OP_R, FN_SLT, 1'b0, E_DECODE);
    step(OP_R, FN_SLT, 1'b0, E_EX_SLT);
    step(OP_R, FN_SLT, 1'b0, E_ALUWB);
    // lw aborted by reset during MEMRD
    step(OP_LW, FN_SUB, 1'b0, E_FETCH);
    step(OP_LW, FN_SUB, 1'b0, E_DECODE);
    step(OP_LW, FN_SUB, 1'b0, E_MEMADR);
    step(OP_LW, FN_SUB, 1'b0, E_MEMRD);
    @(negedge clk); #1; rst_n = 1'b0;
    #1; push(E_RST); -> mon_ev;
    step(OP_J, FN_SUB, 1'b1, E_RST);
    @(posedge clk); #1; rst_n = 1'b1; zero = 1'b0; push(E_FETCH);
    step(OP_J, FN_SUB, 1'b0, E_DECODE);
    step(OP_J, FN_SUB, 1'b0, E_JUMP);
    step(OP_J, FN_SUB, 1'b0, E_FETCH);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, need 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle MIPS-subset control FSM: the producer side of the ALU's control interface.
- Drives alu_cnt and all datapath enables/selects, consumes the ALU zero flag for branch resolution.
- Sits between the instruction register (opcode/funct) and the shared ALU/register-file/memory datapath.
- Executes one instruction at a time over 2–5 cycles.

Parameters:
- none; opcode, funct and alu_cnt encodings below are fixed.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag, same-cycle combinational
- alu_cnt  out  3  ALU op: AND 000, OR 001, ADD 010, SUB 110, SLT 111
- alu_src_a  out  1  0=PC, 1=register A
- alu_src_b  out  2  00=register B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- pc_src  out  2  00=ALU result, 01=ALU-out register, 10=jump target
- iord  out  1  memory address select: 0=PC, 1=ALU-out
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register load
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALU-out, 1=memory data register
- reg_write  out  1  register file write enable
- pc_en  out  1  PC load = pc_write | (branch & zero)
- retire  out  1  one-cycle pulse in the final state of each instruction
- state  out  4  current state encoding, for debug and bench

Behaviour:
- Opcodes:
  - R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- R-type funct:
  - 100000 add→010, 100010 sub→110, 100100 and→000, 100101 or→001, 101010 slt→111.
  - Any other funct → 010.
- Output structure:
  - Moore outputs, decoded combinationally from the state register.
  - Any output not listed for a state is 0; alu_cnt defaults to 010.
- States, their encodings and asserted outputs:
  - FETCH(0): ir_write=1, pc_write=1, alu_src_b=01, alu_cnt=010.
  - DECODE(1): alu_src_b=11, alu_cnt=010 (branch target precompute).
  - MEMADR(2): alu_src_a=1, alu_src_b=10.
  - MEMRD(3): iord=1.
  - MEMWB(4): mem_to_reg=1, reg_write=1, retire=1.
  - MEMWR(5): iord=1, mem_write=1, retire=1.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_cnt=funct decode.
  - ALUWB(7): reg_dst=1, reg_write=1, retire=1.
  - BRANCH(8): alu_src_a=1, alu_cnt=110, pc_src=01, branch=1, retire=1.
  - ADDIEX(9): alu_src_a=1, alu_src_b=10.
  - ADDIWB(10): reg_write=1, retire=1.
  - JUMP(11): pc_src=10, pc_write=1, retire=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw/sw), EXEC (R), BRANCH (beq), ADDIEX (addi), JUMP (j).
  - DECODE→FETCH on unknown opcode; retire=0, executes as a NOP.
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB; EXEC→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP → FETCH.
  - Encodings 12–15 are illegal and go to FETCH next cycle with all outputs at default.
- Latency in cycles, FETCH inclusive: lw 5; sw, R, addi 4; beq, j 3; unknown opcode 2.
- Input sampling:
  - opcode is read in DECODE and MEMADR; funct is read in EXEC.
  - Both must be stable from the cycle after FETCH until retire.
- pc_en is combinational: in BRANCH it follows zero within the same cycle; outside BRANCH, zero is ignored.
- Reset:
  - rst_n low forces state=FETCH immediately, asynchronously.
  - While rst_n is low, mem_write, ir_write, reg_write, pc_en and retire are forced to 0. Other outputs show FETCH values.
  - The first rising edge with rst_n high executes FETCH.
  - Reset asserted mid-instruction aborts it with no further write enables.

Test Plan:
- Reset release, opcode=000000, funct=100010:
  - Cycles show state 0,1,6,7,0.
  - alu_cnt=110 in EXEC; reg_dst=1 and reg_write=1 in ALUWB; retire pulses once.
- lw (100011):
  - State sequence 0,1,2,3,4.
  - iord=1 in MEMRD; mem_to_reg=1 and reg_write=1 in MEMWB; pc_en=1 only in FETCH.
- beq (000100):
  - With zero=1 in BRANCH: pc_en=1, pc_src=01, alu_cnt=110.
  - Repeat with zero=0: pc_en=0. Both cases return to FETCH after 3 cycles.
- sw then j:
  - sw: mem_write=1 only in state 5.
  - j: state 11 with pc_src=10, pc_en=1.
  - Total 7 cycles, two retire pulses.
- Unknown opcode 111111 then addi:
  - Unknown opcode: 0→1→0, no retire.
  - addi: 0,1,9,10, reg_write=1, reg_dst=0.
  - Unknown funct 000000 in R-type gives alu_cnt=010.
- rst_n pulled low in MEMRD:
  - state=0 before the next clock edge; mem_write, reg_write, ir_write and pc_en stay 0 while low.
  - Normal FETCH follows release.
